// File: rtl/vc32_bus_pkg.sv
// Shared types for the execute-side memory bus: arbiter FSM states and grant IDs.
package vc32_bus_pkg;

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   typedef enum logic [1:0] {GNT_I, GNT_DR, GNT_DW, GNT_F} gnt_t;

   function automatic logic gnt_is_read(input gnt_t g);
      return (g == GNT_I) || (g == GNT_DR);
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Clear/enable bus watchdog; expired flags the cycle that completes 2^TO_W-1 enabled cycles.
module bus_watchdog #(
   parameter int TO_W = 6
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] count;
   logic [TO_W-1:0] count_inc;

   assign count_inc = count + {{(TO_W-1){1'b0}}, 1'b1};

   // Judging the post-increment value makes the limit the number of held cycles.
   assign expired = en && (&count_inc);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter serialising fetch, data and flush onto one registered memory bus.
module mem_arbiter
   import vc32_bus_pkg::*;
#(
   parameter int RV   = 32,
   parameter int VA   = RV,
   parameter int TO_W = 6
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic [VA-1:1]        i_addr,
   output logic                 i_done,
   input  logic [1:0]           d_rstrobe,
   input  logic [RV/8-1:0]      d_wmask,
   input  logic [VA-1:RV/16]    d_addr,
   input  logic [RV-1:0]        d_wdata,
   input  logic                 d_io,
   output logic                 d_rdone,
   output logic                 d_wdone,
   input  logic                 f_req,
   input  logic [VA-1:RV/16]    f_addr,
   input  logic [RV-1:0]        f_wdata,
   output logic                 f_done,
   output logic [RV-1:0]        rdata,
   output logic                 m_rd,
   output logic                 m_wr,
   output logic [VA-1:RV/16]    m_addr,
   output logic [RV-1:0]        m_wdata,
   output logic [RV/8-1:0]      m_wmask,
   output logic                 m_io,
   input  logic                 m_ready,
   input  logic [RV-1:0]        m_rdata,
   output logic                 bus_fault
);

   state_t                state, state_nx;
   gnt_t                  gnt, gnt_nx;
   logic [VA-1:RV/16]     addr_nx;
   logic [RV-1:0]         wdata_nx, rdata_nx;
   logic [RV/8-1:0]       wmask_nx;
   logic                  rd_nx, wr_nx, io_nx, fault_nx;
   logic                  i_done_nx, d_rdone_nx, d_wdone_nx, f_done_nx;
   logic                  wd_clr, wd_en, wd_expired;
   logic                  unused_ibits;

   // Sub-word fetch address bits never reach the word-addressed bus.
   assign unused_ibits = ^i_addr;

   bus_watchdog #(.TO_W(TO_W)) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_comb begin
      state_nx   = state;
      gnt_nx     = gnt;
      addr_nx    = m_addr;
      wdata_nx   = m_wdata;
      wmask_nx   = m_wmask;
      io_nx      = m_io;
      rd_nx      = m_rd;
      wr_nx      = m_wr;
      rdata_nx   = rdata;
      fault_nx   = 1'b0;
      i_done_nx  = 1'b0;
      d_rdone_nx = 1'b0;
      d_wdone_nx = 1'b0;
      f_done_nx  = 1'b0;
      wd_clr     = 1'b0;
      wd_en      = 1'b0;
      unique case (state)
         IDLE: begin
            wd_clr = 1'b1;
            if (d_wmask != '0) begin
               gnt_nx = GNT_DW; addr_nx = d_addr; wdata_nx = d_wdata;
               wmask_nx = d_wmask; io_nx = d_io; wr_nx = 1'b1; state_nx = BUS;
            end else if (d_rstrobe != '0) begin
               gnt_nx = GNT_DR; addr_nx = d_addr; wdata_nx = '0;
               wmask_nx = '1; io_nx = d_io; rd_nx = 1'b1; state_nx = BUS;
            end else if (f_req) begin
               gnt_nx = GNT_F; addr_nx = f_addr; wdata_nx = f_wdata;
               wmask_nx = '1; io_nx = 1'b0; wr_nx = 1'b1; state_nx = BUS;
            end else if (i_req) begin
               gnt_nx = GNT_I; addr_nx = i_addr[VA-1:RV/16]; wdata_nx = '0;
               wmask_nx = '1; io_nx = 1'b0; rd_nx = 1'b1; state_nx = BUS;
            end
         end
         BUS: begin
            wd_en = 1'b1;
            if (m_ready || wd_expired) begin
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
               state_nx = DONE;
               if (!m_ready) begin
                  fault_nx = 1'b1;
                  rdata_nx = '0;
               end else if (gnt_is_read(gnt)) begin
                  rdata_nx = m_rdata;
               end
               unique case (gnt)
                  GNT_I:  i_done_nx  = 1'b1;
                  GNT_DR: d_rdone_nx = 1'b1;
                  GNT_DW: d_wdone_nx = 1'b1;
                  GNT_F:  f_done_nx  = 1'b1;
               endcase
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         gnt       <= GNT_I;
         m_addr    <= '0;
         m_wdata   <= '0;
         m_wmask   <= '0;
         m_io      <= 1'b0;
         m_rd      <= 1'b0;
         m_wr      <= 1'b0;
         rdata     <= '0;
         bus_fault <= 1'b0;
         i_done    <= 1'b0;
         d_rdone   <= 1'b0;
         d_wdone   <= 1'b0;
         f_done    <= 1'b0;
      end else begin
         state     <= state_nx;
         gnt       <= gnt_nx;
         m_addr    <= addr_nx;
         m_wdata   <= wdata_nx;
         m_wmask   <= wmask_nx;
         m_io      <= io_nx;
         m_rd      <= rd_nx;
         m_wr      <= wr_nx;
         rdata     <= rdata_nx;
         bus_fault <= fault_nx;
         i_done    <= i_done_nx;
         d_rdone   <= d_rdone_nx;
         d_wdone   <= d_wdone_nx;
         f_done    <= f_done_nx;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a priority/latency reference model.
module tb_mem_arbiter;

   localparam int RV   = 32;
   localparam int VA   = 32;
   localparam int TO_W = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_req;
   logic [31:1]   i_addr;
   logic          i_done;
   logic [1:0]    d_rstrobe;
   logic [3:0]    d_wmask;
   logic [31:2]   d_addr;
   logic [31:0]   d_wdata;
   logic          d_io;
   logic          d_rdone, d_wdone;
   logic          f_req;
   logic [31:2]   f_addr;
   logic [31:0]   f_wdata;
   logic          f_done;
   logic [31:0]   rdata;
   logic          m_rd, m_wr;
   logic [31:2]   m_addr;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wmask;
   logic          m_io;
   logic          m_ready;
   logic [31:0]   m_rdata;
   logic          bus_fault;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            last_done = 0;
   bit            tie_ready = 1'b0;
   logic [31:0]   exp_rdata = '0;
   int            t[3];

   mem_arbiter #(.RV(RV), .VA(VA), .TO_W(TO_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
      .d_rstrobe(d_rstrobe), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_io(d_io), .d_rdone(d_rdone), .d_wdone(d_wdone),
      .f_req(f_req), .f_addr(f_addr), .f_wdata(f_wdata), .f_done(f_done),
      .rdata(rdata), .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wmask(m_wmask), .m_io(m_io), .m_ready(m_ready), .m_rdata(m_rdata),
      .bus_fault(bus_fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {i_done, d_rdone, d_wdone, f_done, m_rd, m_wr, m_io, bus_fault}, 0);
      chk({tag, "_addr"}, m_addr, 0);
      chk({tag, "_wdata"}, m_wdata, 0);
      chk({tag, "_mask"}, m_wmask, 0);
      chk({tag, "_rdata"}, rdata, 0);
   endtask

   // Reference priority: 1=data write, 2=data read, 3=flush, 4=fetch, 0=none.
   function automatic int pick();
      if (d_wmask != 0)   return 1;
      if (d_rstrobe != 0) return 2;
      if (f_req)          return 3;
      if (i_req)          return 4;
      return 0;
   endfunction

   // lat >= 0: m_ready after lat stalled bus cycles; lat < 0: never ready (watchdog).
   task automatic txn(input int lat, input logic [31:0] rdv);
      int          g;
      int          held;
      logic        e_rd, e_io, e_fault;
      logic [29:0] e_addr;
      logic [3:0]  e_mask, e_done;
      logic [31:0] e_wd, byte_addr;
      g = pick();
      if (g == 0) chk("no_request", 0, 1);
      case (g)
         1: begin e_rd = 0; e_addr = d_addr; e_mask = d_wmask; e_wd = d_wdata; e_io = d_io; e_done = 4'b0010; end
         2: begin e_rd = 1; e_addr = d_addr; e_mask = 4'hF; e_wd = 0; e_io = d_io; e_done = 4'b0100; end
         3: begin e_rd = 0; e_addr = f_addr; e_mask = 4'hF; e_wd = f_wdata; e_io = 0; e_done = 4'b0001; end
         default: begin
            byte_addr = {i_addr, 1'b0};
            e_rd = 1; e_addr = 30'(byte_addr >> 2); e_mask = 4'hF; e_wd = 0; e_io = 0; e_done = 4'b1000;
         end
      endcase
      @(posedge clk); #1;
      chk("cmd", {m_rd, m_wr, m_io}, {e_rd, !e_rd, e_io});
      chk("addr", m_addr, e_addr);
      chk("mask", m_wmask, e_mask);
      if (!e_rd) chk("wdata", m_wdata, e_wd);
      held = 1;
      if (lat >= 0) begin
         for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            chk("hold", {m_rd, m_wr, m_io, m_addr}, {e_rd, !e_rd, e_io, e_addr});
            held++;
         end
         m_rdata = rdv;
         m_ready = 1'b1;
         @(posedge clk); #1;
         if (!tie_ready) m_ready = 1'b0;
         e_fault = 0;
         if (e_rd) exp_rdata = rdv;
      end else begin
         m_ready = 1'b0;
         for (int k = 0; k < 100 && (m_rd || m_wr); k++) begin
            @(posedge clk); #1;
            if (m_rd || m_wr) held++;
         end
         chk("timeout_hold", held, (1 << TO_W) - 1);
         e_fault = 1;
         exp_rdata = '0;
      end
      chk("done", {i_done, d_rdone, d_wdone, f_done}, e_done);
      chk("rdata", rdata, exp_rdata);
      chk("fault", bus_fault, e_fault);
      chk("cmd_drop", {m_rd, m_wr}, 0);
      last_done = cyc;
      case (g)
         1: d_wmask = '0;
         2: d_rstrobe = '0;
         3: f_req = 1'b0;
         default: i_req = 1'b0;
      endcase
      @(posedge clk); #1;
      chk("idle", {i_done, d_rdone, d_wdone, f_done, m_rd, m_wr, bus_fault}, 0);
   endtask

   initial begin
      reset_n = 1'b0; i_req = 0; i_addr = '0; d_rstrobe = '0; d_wmask = '0;
      d_addr = '0; d_wdata = '0; d_io = 0; f_req = 0; f_addr = '0; f_wdata = '0;
      m_ready = 0; m_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // m_ready outside a transaction is ignored
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("stray_ready", {i_done, d_rdone, d_wdone, f_done, m_rd, m_wr, bus_fault}, 0);
      end
      m_ready = 1'b0;

      // fetch at halfword 0x10 -> word address 0x8 (byte 0x20)
      i_req = 1; i_addr = 31'h10;
      txn(2, 32'h1234_5678);
      chk("fetch_rdata", rdata, 32'h1234_5678);

      // write, flush, fetch pending together with m_ready tied high
      tie_ready = 1'b1; m_ready = 1'b1;
      i_req = 1; i_addr = 31'h0ABC;
      f_req = 1; f_addr = 30'h155; f_wdata = 32'hF00D_0001;
      d_wmask = 4'b0010; d_addr = 30'h2AA; d_wdata = 32'hCAFE_BEEF; d_io = 0;
      for (int k = 0; k < 3; k++) begin
         txn(0, $urandom);
         t[k] = last_done;
      end
      chk("gap1", t[1] - t[0], 3);
      chk("gap2", t[2] - t[1], 3);
      tie_ready = 1'b0; m_ready = 1'b0;

      // read and write strobes together: write wins
      d_rstrobe = 2'b01; d_wmask = 4'hF; d_addr = 30'h123; d_wdata = 32'h0BAD_F00D;
      txn(1, $urandom);
      d_rstrobe = '0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("no_rdone", {d_rdone, m_rd}, 0);
      end

      // watchdog abort of a write that never completes
      d_wmask = 4'hC; d_addr = 30'h3F0; d_wdata = 32'h5555_AAAA;
      txn(-1, '0);

      // asynchronous reset in the middle of a bus cycle
      i_req = 1; i_addr = 31'h4444;
      txn(0, 32'h7777_1111);
      i_req = 1; i_addr = 31'h2002;
      @(posedge clk); #1;
      chk("pre_reset_cmd", m_rd, 1);
      reset_n = 1'b0;
      #1;
      chk_zero("async_reset");
      exp_rdata = '0;
      repeat (2) begin
         @(posedge clk); #1;
         chk_zero("in_reset");
      end
      reset_n = 1'b1;
      txn(1, 32'h89AB_CDEF);

      // IO read keeps m_io throughout; a following fetch does not
      d_io = 1; d_rstrobe = 2'b01; d_addr = 30'h0FF;
      txn(2, 32'h0102_0304);
      i_req = 1; i_addr = 31'h0100;
      txn(0, 32'hDEAD_0001);
      d_io = 0;

      // randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            d_wmask = 4'($urandom_range(1, 15)); d_wdata = $urandom;
         end
         if ($urandom_range(0, 3) == 0) d_rstrobe = 2'($urandom_range(1, 3));
         d_addr = 30'($urandom);
         d_io = 1'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            f_req = 1; f_addr = 30'($urandom); f_wdata = $urandom;
         end
         if ($urandom_range(0, 1) == 0) begin
            i_req = 1; i_addr = 31'($urandom);
         end
         if (pick() == 0) i_req = 1;
         txn(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
